// File: rtl/sp_ram_be_init.sv
// sp_ram_be_init: single-port synchronous RAM with per-byte write enables,
// a RD_LATENCY-stage registered read pipe with read-valid strobe, a hardware
// init sweep (after reset and on clr) and an out-of-range error strobe.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   cs        request valid
//   we        1 = write, 0 = read
//   be        byte write enables, be[i] covers data_in[8i+7:8i]
//   oe        gates data_out only (no effect on the pipe or rd_valid)
//   addr      word address
//   data_in   write data
//   clr       1-cycle pulse, re-runs the init sweep (ignored while busy)
//   data_out  read data, oe ? pipe data : '0
//   rd_valid  1-cycle strobe, read data valid
//   busy      high during reset and init sweep; requests ignored
//   err       1-cycle strobe, request addressed a word >= DEPTH
module sp_ram_be_init #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 4,
    parameter int unsigned          DEPTH      = 2 ** ADDR_WIDTH,
    parameter int unsigned          RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    oe,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    clr,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Elaboration-time parameter sanity checks
    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 2 || DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
        $error("DEPTH out of range");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_lat
        $error("RD_LATENCY out of range");
    end

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_addr;
    logic [DATA_WIDTH-1:0]   mem       [DEPTH];
    logic [DATA_WIDTH-1:0]   pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0]   pipe_vld;

    logic                    in_range_c;
    logic                    req_c;
    logic                    wr_c;
    logic                    rd_c;
    logic [DATA_WIDTH-1:0]   rd_data_c;

    // Request qualification; a same-cycle clr drops the request
    assign in_range_c = {1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign req_c      = (state == READY) && cs && !clr;
    assign wr_c       = !rst && req_c && we && in_range_c;
    assign rd_c       = req_c && !we;
    assign rd_data_c  = in_range_c ? mem[addr] : '0;

    // Storage: sweep writes have priority; rst alone never touches contents
    always_ff @(posedge clk) begin
        if (!rst && state == INIT) begin
            mem[sweep_addr] <= INIT_VALUE;
        end else if (wr_c) begin
            for (int i = 0; i < int'(NUM_BYTES); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Control FSM, read pipe and status strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            sweep_addr <= '0;
            busy       <= 1'b1;
            err        <= 1'b0;
            pipe_vld   <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            err          <= req_c && !in_range_c;
            pipe_vld[0]  <= rd_c;
            pipe_data[0] <= rd_c ? rd_data_c : '0;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end

            case (state)
                INIT: begin
                    // Counter stops at the last word rather than wrapping
                    if (sweep_addr == LAST_ADDR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
                    end
                end
                READY: begin
                    if (clr) begin
                        state      <= INIT;
                        sweep_addr <= '0;
                        busy       <= 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rd_valid = pipe_vld[RD_LATENCY-1];
    assign data_out = oe ? pipe_data[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_sp_ram_be_init.sv
// Scoreboard bench for sp_ram_be_init (DEPTH=12, RD_LATENCY=2, nonzero init word).
module tb_sp_ram_be_init;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] INITV = 32'h5A5A_C3C3;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        we;
    logic [3:0]  be;
    logic        oe;
    logic [3:0]  addr;
    logic [31:0] data_in;
    logic        clr;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        busy;
    logic        err;

    sp_ram_be_init #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RD_LATENCY (LAT),
        .INIT_VALUE (INITV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .be       (be),
        .oe       (oe),
        .addr     (addr),
        .data_in  (data_in),
        .clr      (clr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [DEPTH];
    bit          ready;
    int          sweep;
    bit          exp_busy;
    bit          exp_err;
    bit          exp_dout_zero;
    bit          checking = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: sample half a cycle after each edge
    always @(negedge clk) begin
        if (checking) begin
            bit exp_v;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("err", 32'(err), 32'(exp_err));
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            chk("rd_valid", 32'(rd_valid), 32'(exp_v));
            if (exp_v) begin
                exp_t e;
                e = q.pop_front();
                chk("data_out", data_out, oe ? e.data : 32'h0);
            end
            if (exp_dout_zero) chk("reset_data_out", data_out, 32'h0);
        end
    end

    // Drive one cycle of inputs, then advance the reference model by one edge
    task automatic step(input logic r, input logic c, input logic w, input logic [3:0] b,
                        input logic [3:0] a, input logic [31:0] d, input logic cl,
                        input logic o);
        bit oor;
        rst = r; cs = c; we = w; be = b; addr = a; data_in = d; clr = cl; oe = o;
        @(posedge clk);
        #1;
        oor           = int'(a) >= int'(DEPTH);
        exp_dout_zero = 0;
        exp_err       = 0;
        if (r) begin
            ready = 0; sweep = 0; q.delete();
            exp_busy = 1; exp_dout_zero = 1; checking = 1;
        end else if (!ready) begin
            mdl[sweep] = INITV;
            sweep++;
            if (sweep == int'(DEPTH)) ready = 1;
            exp_busy = !ready;
        end else if (cl) begin
            ready = 0; sweep = 0; exp_busy = 1;
        end else begin
            exp_busy = 0;
            exp_err  = c && oor;
            if (c && w && !oor) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
            end
            if (c && !w) q.push_back('{cyc + int'(LAT) - 1, oor ? 32'h0 : mdl[a]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 4'h0, 32'h0, 0, 1'($urandom));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        step(0, 1, 1, b, a, d, 0, 1);
    endtask

    task automatic rd(input logic [3:0] a, input logic o);
        step(0, 1, 0, 4'h0, a, 32'h0, 0, o);
    endtask

    task automatic read_all();
        for (int i = 0; i < int'(DEPTH); i++) rd(4'(i), 1'($urandom));
        idle(int'(LAT) + 1);
    endtask

    initial begin
        rst = 1; cs = 0; we = 0; be = 0; oe = 0; addr = 0; data_in = 0; clr = 0;

        // Reset and full init sweep, then every word holds the init value
        for (int i = 0; i < 3; i++) step(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 1);
        idle(int'(DEPTH) + 2);
        read_all();

        // Byte enables
        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        wr(4'd3, 32'h1122_3344, 4'b0101);
        wr(4'd4, 32'hFFFF_FFFF, 4'h0);
        rd(4'd3, 1);
        rd(4'd4, 1);
        idle(3);

        // Back-to-back reads, oe low then high
        for (int i = 0; i < 4; i++) rd(4'd3, 0);
        for (int i = 0; i < 4; i++) rd(4'(i + 2), 1);
        idle(3);

        // Out-of-range write and read
        wr(4'd13, 32'h1234_5678, 4'hF);
        rd(4'd13, 1);
        rd(4'd15, 1);
        rd(4'd11, 1);
        idle(3);

        // clr with a same-cycle write; cs ignored while busy
        step(0, 1, 1, 4'hF, 4'd5, 32'hAAAA_5555, 1, 1);
        for (int i = 0; i < int'(DEPTH) + 2; i++)
            step(0, 1, 1'($urandom), 4'hF, 4'($urandom_range(0, 15)), $urandom, 1'($urandom), 1);
        read_all();

        // rst while the sweep is at address 7
        wr(4'd2, 32'hCAFE_F00D, 4'hF);
        step(0, 0, 0, 4'h0, 4'h0, 32'h0, 1, 1);
        idle(7);
        step(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 1);
        step(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 1);
        idle(int'(DEPTH) + 2);
        read_all();

        // rst in the middle of a read
        rd(4'd1, 1);
        step(1, 1, 0, 4'h0, 4'd1, 32'h0, 0, 1);
        idle(int'(DEPTH) + 2);

        // Randomized traffic with occasional clr and rst
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 4'($urandom), 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 39) == 0, 1'($urandom));
        end
        idle(int'(DEPTH) + 4);
        read_all();

        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
